// File: rtl/bin2bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter that feeds
// the 4-digit 7-segment driver: FSM encoding, clamp limit, reset constants
// and the leading-zero mask helper.
package bin2bcd_pkg;

    // Converter FSM encoding; also exported on the debug state output.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CONV   = 2'd1,
        FINISH = 2'd2
    } state_t;

    // Largest value that fits in four decimal digits; larger inputs clamp.
    localparam logic [13:0] BCD_MAX   = 14'd9999;

    // Output values after reset: display reads "   0".
    localparam logic [15:0] BCD_RST   = 16'h0000;
    localparam logic [3:0]  BLANK_RST = 4'b1110;

    // Bit counter width; WIDTH is at most 14 so 4 bits suffice.
    localparam int CNT_W = 4;

    // Leading-zero mask for a packed 4-digit BCD word. Digit 0 is never
    // blanked so a zero value still shows a single "0".
    function automatic logic [3:0] blank_mask(input logic [15:0] d);
        logic b3;
        logic b2;
        logic b1;
        b3 = (d[15:12] == 4'd0);
        b2 = b3 && (d[11:8] == 4'd0);
        b1 = b2 && (d[7:4] == 4'd0);
        return {b3, b2, b1, 1'b0};
    endfunction

endpackage

// File: rtl/bin2bcd_seq_if.sv
// Request/result bundle between the display register logic (master) and the
// binary-to-BCD converter (slave).
//
// Handshake: the converter is ready exactly when busy is low. A request is
// accepted on a rising edge where start=1 and busy=0; bin is sampled on that
// edge only. start seen while busy=1 is dropped, not queued. The result
// (bcd_out, ovf, blank) updates on the edge that raises done for one cycle
// and holds until the next done or reset.
interface bin2bcd_seq_if
    import bin2bcd_pkg::*;
#(
    parameter int WIDTH = 14
);
    logic             start;
    logic [WIDTH-1:0] bin;
    logic             busy;
    logic             done;
    logic [15:0]      bcd_out;
    logic             ovf;
    logic [3:0]       blank;
    state_t           dbg_state;

    modport master (
        output start,
        output bin,
        input  busy,
        input  done,
        input  bcd_out,
        input  ovf,
        input  blank,
        input  dbg_state
    );

    modport slave (
        input  start,
        input  bin,
        output busy,
        output done,
        output bcd_out,
        output ovf,
        output blank,
        output dbg_state
    );
endinterface

// File: rtl/bin2bcd_add3.sv
// Double-dabble correction cell for one BCD nibble: values 5..9 get +3 so
// that the following left shift carries correctly into the next digit.
module bcd_add3 (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    // Combinational add-3-if-at-least-5 correction.
    assign dout = (din >= 4'd5) ? (din + 4'd3) : din;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter, one input bit per clock. Converts the
// display register value to a packed 4-digit BCD word for the 7-segment
// driver. Results are held in dedicated output registers that only change
// on completion or reset, so the multiplexed display never sees a partial
// value. Inputs above 9999 are clamped and flagged via ovf.
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int WIDTH  = 14,  // binary input width, 4..14
    parameter int DIGITS = 4    // BCD digits; the display word is 4 digits
)(
    input  logic             clk,
    input  logic             clr_n,
    bin2bcd_seq_if.slave     bus
);

    localparam int SW = 4 * DIGITS;  // scratch width, 16 bits

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] shift;
    logic [SW-1:0]    scratch;
    logic             ovf_pending;
    logic             busy_q;
    logic             done_q;
    logic [15:0]      bcd_q;
    logic             ovf_q;
    logic [3:0]       blank_q;

    // Input clamp: anything above 9999 converts as 9999. The input is
    // zero-extended to 14 bits so the compare is valid for every WIDTH;
    // for WIDTH<14 the compare can never be true.
    logic [13:0]      bin_ext;
    logic             clamp;
    logic [WIDTH-1:0] bin_cap;

    assign bin_ext = 14'(bus.bin);
    assign clamp   = (bin_ext > BCD_MAX);
    assign bin_cap = clamp ? WIDTH'(BCD_MAX) : bus.bin;

    // Dabble step: correct every digit, then shift {scratch, shift} left by
    // one as a single wide register. With the input clamped no digit ever
    // exceeds 9, so the bit shifted out of the top is always zero.
    logic [SW-1:0]       adj;
    logic [SW+WIDTH-1:0] dd_next;

    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .din  (scratch[4*g +: 4]),
            .dout (adj[4*g +: 4])
        );
    end

    assign dd_next = {adj, shift} << 1;

    // Converter FSM: capture in IDLE, WIDTH shift steps in CONV, publish the
    // result and pulse done in FINISH.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state       <= IDLE;
            cnt         <= '0;
            shift       <= '0;
            scratch     <= '0;
            ovf_pending <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            bcd_q       <= BCD_RST;
            ovf_q       <= 1'b0;
            blank_q     <= BLANK_RST;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        shift       <= bin_cap;
                        scratch     <= '0;
                        cnt         <= CNT_W'(WIDTH);
                        ovf_pending <= clamp;
                        busy_q      <= 1'b1;
                        state       <= CONV;
                    end
                end
                CONV: begin
                    scratch <= dd_next[SW+WIDTH-1:WIDTH];
                    shift   <= dd_next[WIDTH-1:0];
                    cnt     <= cnt - CNT_W'(1);
                    // Last of the WIDTH shift steps.
                    if (cnt == CNT_W'(1)) begin
                        state <= FINISH;
                    end
                end
                FINISH: begin
                    bcd_q   <= scratch[15:0];
                    ovf_q   <= ovf_pending;
                    blank_q <= blank_mask(scratch[15:0]);
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.bcd_out   = bcd_q;
    assign bus.ovf       = ovf_q;
    assign bus.blank     = blank_q;
    assign bus.dbg_state = state;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed bench for bin2bcd_seq: expected results come from a decimal
// division model, are queued when a request is driven and are checked when
// done pulses.
module tb_bin2bcd_seq;
    import bin2bcd_pkg::*;

    localparam int WIDTH = 14;

    // Clock and reset
    logic clk   = 1'b0;
    logic clr_n = 1'b0;
    always #5 clk = ~clk;

    bin2bcd_seq_if #(.WIDTH(WIDTH)) bus ();

    bin2bcd_seq #(.WIDTH(WIDTH), .DIGITS(4)) dut (
        .clk   (clk),
        .clr_n (clr_n),
        .bus   (bus)
    );

    // Scoreboard: {ovf, blank[3:0], bcd[15:0]}
    logic [20:0] exp_q[$];
    logic [20:0] mon_e;
    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: clamp, then decimal digits by division.
    function automatic logic [20:0] model(input int v);
        int          c;
        logic [15:0] d;
        logic [3:0]  b;
        c = (v > 9999) ? 9999 : v;
        d = {4'(c / 1000), 4'((c / 100) % 10), 4'((c / 10) % 10), 4'(c % 10)};
        b = {(c < 1000), (c < 100), (c < 10), 1'b0};
        return {(v > 9999), b, d};
    endfunction

    // Result monitor: every done pulse must match the oldest queued request.
    always @(negedge clk) begin
        if (clr_n && bus.done) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("bcd_out", 32'(bus.bcd_out), 32'(mon_e[15:0]));
                check("blank", 32'(bus.blank), 32'(mon_e[19:16]));
                check("ovf", 32'(bus.ovf), 32'(mon_e[20]));
            end
        end
    end

    // Driver: one-cycle start pulse, then measure latency and busy length.
    task automatic run_conv(input int v, input string tag);
        int lat;
        int busy_n;
        @(posedge clk); #1;
        bus.bin   = 14'(v);
        bus.start = 1'b1;
        exp_q.push_back(model(v));
        @(posedge clk); #1;          // accepted on this edge
        bus.start = 1'b0;
        busy_n = int'(bus.busy);
        lat    = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (bus.done) begin
                lat = i;
                break;
            end
            busy_n += int'(bus.busy);
        end
        check({tag, "_latency"}, 32'(lat), 32'(WIDTH + 1));
        check({tag, "_busy_cycles"}, 32'(busy_n), 32'(WIDTH + 1));
        @(negedge clk);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_bcd"}, 32'(bus.bcd_out), 32'h0000);
        check({tag, "_blank"}, 32'(bus.blank), 32'b1110);
        check({tag, "_busy"}, 32'(bus.busy), 32'd0);
        check({tag, "_done"}, 32'(bus.done), 32'd0);
        check({tag, "_ovf"}, 32'(bus.ovf), 32'd0);
        check({tag, "_state"}, 32'(bus.dbg_state), 32'(IDLE));
    endtask

    // Watchdog
    initial begin
        #1000000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

    // Directed sequence
    initial begin
        int d0;
        int n;
        int t1;
        int t2;
        bus.start = 1'b0;
        bus.bin   = '0;

        // Reset, then idle with no start.
        repeat (3) @(posedge clk);
        #1 clr_n = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");

        // Basic conversions and clamp boundary.
        run_conv(1234, "c1234");
        run_conv(7, "c7");
        run_conv(0, "c0");
        run_conv(9999, "c9999");
        run_conv(12000, "c12000");
        run_conv(50, "c50");
        run_conv(16383, "cmax");

        // Start during busy is ignored.
        @(posedge clk); #1;
        bus.bin   = 14'(42);
        bus.start = 1'b1;
        exp_q.push_back(model(42));
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        bus.bin   = 14'(8888);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.bin   = '0;
        d0 = done_cnt;
        repeat (30) @(negedge clk);
        check("ignored_single_done", 32'(done_cnt - d0), 32'd1);
        check("ignored_queue_empty", 32'(exp_q.size()), 32'd0);

        // Reset in the middle of a conversion.
        @(posedge clk); #1;
        bus.bin   = 14'(5678);
        bus.start = 1'b1;
        exp_q.push_back(model(5678));
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (7) @(posedge clk);
        #1 clr_n = 1'b0;
        #1;
        check_reset_vals("midrst");
        void'(exp_q.pop_back());
        d0 = done_cnt;
        @(posedge clk); #1 clr_n = 1'b1;
        repeat (25) @(negedge clk);
        check("midrst_no_done", 32'(done_cnt - d0), 32'd0);
        run_conv(5678, "c5678_after_rst");

        // Start held high: back-to-back conversions every WIDTH+2 cycles.
        @(posedge clk); #1;
        bus.bin   = 14'(321);
        bus.start = 1'b1;
        exp_q.push_back(model(321));
        exp_q.push_back(model(321));
        n  = 0;
        t1 = 0;
        t2 = 0;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk); #1;
            if (bus.done) begin
                n++;
                if (n == 1) t1 = i;
                if (n == 2) begin
                    t2 = i;
                    break;
                end
            end
        end
        bus.start = 1'b0;
        check("held_done_count", 32'(n), 32'd2);
        check("held_period", 32'(t2 - t1), 32'(WIDTH + 2));
        repeat (25) @(negedge clk);
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
- Sequential double-dabble converter that sits directly upstream of the 4-digit 7-segment driver.
- Takes an unsigned binary value from the MIPS core's display register and produces the packed 16-bit BCD word (4 nibbles, digit 3 in [15:12]) that feeds the driver's hex input, so the display reads decimal instead of hex.
- One bit converted per clock.
- Output stays stable between conversions so the multiplexed display never shows partial results.

Parameters:
- WIDTH, 14, binary input width; legal range 4..14.
- DIGITS, 4, BCD digits produced; fixed at 4 to match the 16-bit display word.

Ports:
- clk  in  1  system clock, all state on rising edge
- clr_n  in  1  asynchronous active-low reset
- start  in  1  request conversion of bin; sampled on rising edge
- bin  in  WIDTH  unsigned binary value; sampled only in the cycle start is accepted
- busy  out  1  high while a conversion is in progress
- done  out  1  one-cycle pulse when bcd_out/ovf/blank update
- bcd_out  out  16  packed BCD result, digit i in [4i+3:4i]
- ovf  out  1  last accepted bin exceeded 9999 and was clamped
- blank  out  4  leading-zero mask, bit i=1 means digit i is a leading zero; bit 0 always 0

Behaviour:
- Reset: clr_n low asynchronously forces the following, regardless of state:
  - state=IDLE, busy=0, done=0
  - bcd_out=16'h0000, ovf=0, blank=4'b1110
  - shift/scratch registers and counter cleared
- States: IDLE, CONV, FINISH.
- IDLE:
  - start=1 at edge k: capture bin into the shift register; state goes to CONV, busy=1 from edge k.
  - Capture uses min(bin, 9999); ovf_pending is set if bin>9999. WIDTH<14 can never clamp.
  - BCD scratch is cleared to 0 and bit counter is loaded with WIDTH.
- CONV, each edge:
  - Add 3 to every scratch nibble >=5.
  - Then shift {scratch, shift} left by 1 and decrement the counter.
  - After exactly WIDTH CONV edges (edges k+1..k+WIDTH), go to FINISH.
- FINISH, edge k+WIDTH+1:
  - bcd_out<=scratch, ovf<=ovf_pending, blank<=mask computed from scratch.
  - done=1 for this one cycle, busy=0, state goes to IDLE.
- Latency: WIDTH+1 edges from start acceptance to done. Default is 15.
- A new start is accepted in the cycle after done, i.e. back-to-back throughput is one result per WIDTH+2 cycles.
- start while busy=1 is ignored; it is not queued, and bin changes during CONV have no effect.
- start held high continuously: re-converts each time IDLE is re-entered.
- bcd_out, ovf and blank change only at the FINISH edge or reset. No glitch or partial value is ever visible.
- Blank mask:
  - blank[3]=(d3==0).
  - blank[2]=blank[3]&(d2==0).
  - blank[1]=blank[2]&(d1==0).
  - blank[0]=0.
- Reset mid-conversion: conversion is abandoned, outputs take reset values, and done is not pulsed.
- Scratch width is 16 bits. With the input clamped to <=9999, no digit ever exceeds 9 and no carry leaves digit 3.

Decomposition:
- Shared package bin2bcd_pkg:
  - state encoding (IDLE=2'd0, CONV=2'd1, FINISH=2'd2)
  - BCD_MAX=9999
  - reset constants BCD_RST=16'h0000, BLANK_RST=4'b1110
- One natural sub-module: bcd_add3 (combinational nibble cell, out = in>=5 ? in+3 : in). It is instantiated DIGITS times in the dabble step.
- The FSM, counter and output registers stay in bin2bcd_seq.

Test Plan:
- Reset release, no start: bcd_out=16'h0000, blank=4'b1110, busy=0, done=0, ovf=0.
- start with bin=1234 for one cycle:
  - busy=1 for 15 cycles.
  - done pulses exactly 15 edges after acceptance.
  - bcd_out=16'h1234, blank=4'b0000, ovf=0.
- bin=7 then bin=0, sequential conversions:
  - bcd_out=16'h0007 with blank=4'b1110.
  - then bcd_out=16'h0000 with blank=4'b1110.
- bin=9999 gives bcd_out=16'h9999, ovf=0. Next, bin=12000 gives bcd_out=16'h9999, ovf=1. Next, bin=50 gives 16'h0050, ovf=0, blank=4'b1100.
- Issue bin=42 and start; at cycle 5 of busy, pulse start with bin=8888:
  - second request ignored
  - single done, bcd_out=16'h0042
  - next done only after a fresh start in IDLE
- Pulse clr_n low for 1 cycle at cycle 8 of a conversion of 5678:
  - outputs return to reset values immediately, busy=0, no done pulse.
  - subsequent start with 5678 yields 16'h5678 after 15 edges.
